// File: rtl/vramp_slope_monitor.sv
// vramp_slope_monitor
// Clocked slope / threshold monitor for one real-valued analog node.
// Samples vin on every rising clk edge, flags rising / falling / steady
// slope and times 10%-90% rise and fall transitions in clock cycles.
//
// Optional build macro: VRAMP_RAIL_CHK_EN
//   defined   -> rail_err latches when an enabled sample leaves the rails by more than EPS
//   undefined -> rail_err is tied low and no rail comparison exists
//
// FSM states:
//   state  | meaning
//   IDLE   | disabled or just reset, no sample classified yet
//   LOW    | node at or below V_LO
//   MID    | node between thresholds with no measurement armed
//   RISE   | left V_LO upward, counting cycles until V_HI
//   HIGH   | node at or above V_HI
//   FALL   | left V_HI downward, counting cycles until V_LO

module vramp_slope_monitor #(
    parameter real VDD      = 1.5,
    parameter real VSS      = 0.0,
    parameter real LO_FRAC  = 0.1,
    parameter real HI_FRAC  = 0.9,
    parameter real EPS      = 0.001,
    parameter int  STEADY_N = 4,
    parameter int  CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  real              vin,
    output logic             rising,
    output logic             falling,
    output logic             steady,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] rise_time,
    output logic             rise_valid,
    output logic [CNT_W-1:0] fall_time,
    output logic             fall_valid,
    output logic             abort,
    output logic             overflow,
    output logic             rail_err
);

    localparam real V_LO = VSS + LO_FRAC * (VDD - VSS);
    localparam real V_HI = VSS + HI_FRAC * (VDD - VSS);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int               FLAT_W   = $clog2(STEADY_N + 1);
    localparam logic [FLAT_W-1:0] FLAT_MAX = FLAT_W'(STEADY_N);

    localparam logic [1:0] LVL_UNKNOWN = 2'd0;
    localparam logic [1:0] LVL_LOW     = 2'd1;
    localparam logic [1:0] LVL_MID     = 2'd2;
    localparam logic [1:0] LVL_HIGH    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_MID,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

    state_t            state;
    real               prev;
    logic              prev_valid;
    logic [FLAT_W-1:0] flat_cnt;
    logic [CNT_W-1:0]  cnt;

    real               delta;
    logic              up_step;
    logic              down_step;
    logic              at_lo;
    logic              at_hi;
    logic              above_lo;
    logic              below_hi;
    logic              cnt_sat;
    logic [CNT_W-1:0]  cnt_inc;
    logic [FLAT_W-1:0] flat_inc;

    // Threshold and slope decisions for the sample being taken this edge.
    // Completion tests are inclusive, entry tests are strict.
    always_comb begin
        delta     = vin - prev;
        up_step   = (delta > EPS);
        down_step = (delta < -EPS);
        at_lo     = (vin <= V_LO);
        at_hi     = (vin >= V_HI);
        above_lo  = (vin > V_LO);
        below_hi  = (vin < V_HI);
        cnt_sat   = (cnt == CNT_MAX);
        cnt_inc   = cnt_sat ? cnt : cnt + CNT_W'(1);
        flat_inc  = (flat_cnt == FLAT_MAX) ? flat_cnt : flat_cnt + FLAT_W'(1);
    end

    // Slope flags and flat-run tracking against the previous enabled sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= 0.0;
            prev_valid <= 1'b0;
            flat_cnt   <= '0;
            rising     <= 1'b0;
            falling    <= 1'b0;
            steady     <= 1'b0;
        end else if (!en) begin
            prev_valid <= 1'b0;
            flat_cnt   <= '0;
            rising     <= 1'b0;
            falling    <= 1'b0;
            steady     <= 1'b0;
        end else begin
            prev       <= vin;
            prev_valid <= 1'b1;
            if (prev_valid) begin
                rising  <= up_step;
                falling <= down_step;
                if (!up_step && !down_step) begin
                    flat_cnt <= flat_inc;
                    steady   <= (flat_inc == FLAT_MAX);
                end else begin
                    flat_cnt <= '0;
                    steady   <= 1'b0;
                end
            end else begin
                // first sample after enable has nothing to compare against
                rising   <= 1'b0;
                falling  <= 1'b0;
                flat_cnt <= '0;
                steady   <= 1'b0;
            end
        end
    end

    // Threshold FSM with rise/fall timing; level and pulses registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            level      <= LVL_UNKNOWN;
            rise_time  <= '0;
            rise_valid <= 1'b0;
            fall_time  <= '0;
            fall_valid <= 1'b0;
            abort      <= 1'b0;
            overflow   <= 1'b0;
        end else if (!en) begin
            state      <= S_IDLE;
            level      <= LVL_UNKNOWN;
            rise_valid <= 1'b0;
            fall_valid <= 1'b0;
            abort      <= 1'b0;
        end else begin
            rise_valid <= 1'b0;
            fall_valid <= 1'b0;
            abort      <= 1'b0;
            case (state)
                S_IDLE, S_MID: begin
                    if (at_lo) begin
                        state <= S_LOW;
                        level <= LVL_LOW;
                    end else if (at_hi) begin
                        state <= S_HIGH;
                        level <= LVL_HIGH;
                    end else begin
                        state <= S_MID;
                        level <= LVL_MID;
                    end
                end
                S_LOW: begin
                    if (at_hi) begin
                        // jumped straight across both thresholds within one sample
                        state      <= S_HIGH;
                        level      <= LVL_HIGH;
                        rise_time  <= '0;
                        rise_valid <= 1'b1;
                    end else if (above_lo) begin
                        state <= S_RISE;
                        level <= LVL_MID;
                        cnt   <= '0;
                    end else begin
                        level <= LVL_LOW;
                    end
                end
                S_RISE: begin
                    if (at_hi) begin
                        state      <= S_HIGH;
                        level      <= LVL_HIGH;
                        rise_time  <= cnt_inc;
                        rise_valid <= 1'b1;
                        if (cnt_sat) overflow <= 1'b1;
                    end else if (at_lo) begin
                        state <= S_LOW;
                        level <= LVL_LOW;
                        abort <= 1'b1;
                    end else begin
                        // mid-band reversals keep counting
                        cnt   <= cnt_inc;
                        level <= LVL_MID;
                        if (cnt_sat) overflow <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (at_lo) begin
                        state      <= S_LOW;
                        level      <= LVL_LOW;
                        fall_time  <= '0;
                        fall_valid <= 1'b1;
                    end else if (below_hi) begin
                        state <= S_FALL;
                        level <= LVL_MID;
                        cnt   <= '0;
                    end else begin
                        level <= LVL_HIGH;
                    end
                end
                S_FALL: begin
                    if (at_lo) begin
                        state      <= S_LOW;
                        level      <= LVL_LOW;
                        fall_time  <= cnt_inc;
                        fall_valid <= 1'b1;
                        if (cnt_sat) overflow <= 1'b1;
                    end else if (at_hi) begin
                        state <= S_HIGH;
                        level <= LVL_HIGH;
                        abort <= 1'b1;
                    end else begin
                        cnt   <= cnt_inc;
                        level <= LVL_MID;
                        if (cnt_sat) overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    level <= LVL_UNKNOWN;
                end
            endcase
        end
    end

`ifdef VRAMP_RAIL_CHK_EN
    // Sticky out-of-rail detector; independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rail_err <= 1'b0;
        end else if (en && ((vin > VDD + EPS) || (vin < VSS - EPS))) begin
            rail_err <= 1'b1;
        end
    end
`else
    assign rail_err = 1'b0;
`endif

endmodule

// File: doc/vramp_slope_monitor.md
Name: vramp_slope_monitor

Overview:
Clocked monitor for one real-valued analog node, such as a bitline, wordline or FET gate, in the mixed-signal SRAM models. Samples the node every clock and classifies slope as rising, falling or steady. Tracks threshold state with an FSM and measures 10%–90% rise and fall times in clock cycles. It is the receiving end of the ramp stimulus used in device and array benches: ramps are driven in, and this block checks and times them.

Parameters:
VDD, 1.5, upper rail (real)
VSS, 0.0, lower rail (real)
LO_FRAC, 0.1, low threshold: V_LO = VSS + LO_FRAC*(VDD-VSS) = 0.15
HI_FRAC, 0.9, high threshold: V_HI = VSS + HI_FRAC*(VDD-VSS) = 1.35
EPS, 0.001, slope dead-band (real, volts)
STEADY_N, 4, consecutive flat samples before steady is asserted
CNT_W, 16, width of the time counters

Ports:
clk  in  1  sampling clock, posedge
rst  in  1  synchronous reset, active-high
en  in  1  monitor enable
vin  in  real  monitored node voltage
rising  out  1  vin - previous vin > EPS
falling  out  1  vin - previous vin < -EPS
steady  out  1  |delta| <= EPS for STEADY_N consecutive samples
level  out  2  0=unknown, 1=low, 2=mid, 3=high
rise_time  out  CNT_W  last completed rise, in cycles
rise_valid  out  1  one-cycle pulse when rise_time updates
fall_time  out  CNT_W  last completed fall, in cycles
fall_valid  out  1  one-cycle pulse when fall_time updates
abort  out  1  one-cycle pulse when a measurement is cancelled
overflow  out  1  sticky; a counter saturated
rail_err  out  1  sticky; see Optional Feature

Behaviour:
- All outputs are registered and update on the same posedge that samples vin.
- Reset (rst=1 at posedge): all outputs 0, FSM to IDLE, counters 0, prev_valid 0. Reset mid-measurement discards the measurement with no abort pulse.
- en=0: FSM to IDLE next edge. Pulses and slope flags go to 0. rise_time, fall_time, overflow and rail_err hold. prev_valid clears.
- Slope:
  - Compare vin with the registered previous sample only when prev_valid=1. The first enabled sample gives rising=falling=0.
  - Flat counter increments while |delta| <= EPS, saturates at STEADY_N, and clears on any slope.
- FSM states: IDLE, LOW, MID, RISE, HIGH, FALL.
  - IDLE: on the first enabled sample, vin <= V_LO → LOW; vin >= V_HI → HIGH; otherwise → MID.
  - MID: vin <= V_LO → LOW; vin >= V_HI → HIGH; no measurement.
  - LOW: vin >= V_HI → HIGH, rise_time=0, rise_valid. vin > V_LO → RISE, cnt=0.
  - RISE: cnt++ each sample. vin >= V_HI → HIGH, rise_time=cnt+1 (sample-index difference), rise_valid. vin <= V_LO → LOW, abort. Otherwise stay.
  - HIGH/FALL mirror LOW/RISE: entry on vin < V_HI, completion on vin <= V_LO, fall_time, fall_valid, abort on vin >= V_HI.
- Threshold comparisons: entry into a measurement is strict; completion is inclusive. A mid-band reversal stays in RISE/FALL and keeps counting.
- level encoding: LOW=1, HIGH=3, RISE/FALL/MID=2, IDLE=0.
- Counter saturates at 2^CNT_W-1 and sets overflow. The reported time is the saturated value.
- rise_valid and fall_valid never assert in the same cycle. abort is never coincident with a valid pulse.

Optional Feature:
VRAMP_RAIL_CHK_EN. Defined: rail_err sets (sticky until rst) when an enabled sample has vin > VDD+EPS or vin < VSS-EPS. The FSM is unaffected. Undefined: rail_err tied 0, no comparison logic.

Test Plan:
- Reset, en=1, vin ramps 0.0→1.5 in +0.1/cycle → rising=1 from the 2nd sample. LOW→RISE at 0.2, HIGH at 1.4. rise_time=12, one rise_valid pulse, level=3.
- From 1.5 ramp −0.1/cycle to 0.0 → falling=1, FALL at 1.3, LOW at 0.1. fall_time=12, one fall_valid pulse.
- Hold vin=1.5 for 6 cycles → steady=1 from the 4th flat sample onward. rising=falling=0.
- Ramp 0.0→0.8, then step to 0.1 → abort pulse, state LOW, rise_time unchanged, no rise_valid.
- Assert rst mid-RISE (vin=0.7) → next edge: all outputs 0, level=0. A subsequent ramp from 0.0 yields rise_time=12.
- With VRAMP_RAIL_CHK_EN defined, vin=1.6 for one sample → rail_err=1 and stays 1 until rst. Without the macro, rail_err stays 0.
